// File: rtl/adder_pkg.sv
// Shared types and sizing helpers for the multicycle adder.
// Chunk count and index width are derived here so every user agrees.
package adder_pkg;

   typedef enum logic [1:0] {
      IDLE,
      COMPUTE,
      DONE
   } state_t;

   function automatic int nchunk_f(input int w, input int c);
      return w / c;
   endfunction

   // A single chunk still needs a one-bit index register.
   function automatic int idxw_f(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/multicycle_adder_chunk_adder.sv
// One CHUNK_W-bit ripple slice, shared across all digits of an operation.
// Purely combinational; carry is threaded through a register in the top.
module chunk_adder #(
   parameter int CHUNK_W = 4
) (
   input  logic [CHUNK_W-1:0] a,
   input  logic [CHUNK_W-1:0] b,
   input  logic               cin,
   output logic [CHUNK_W-1:0] s,
   output logic               cout
);

   logic [CHUNK_W:0] sum;

   assign sum  = {1'b0, a} + {1'b0, b} + {{CHUNK_W{1'b0}}, cin};
   assign s    = sum[CHUNK_W-1:0];
   assign cout = sum[CHUNK_W];

endmodule

// File: rtl/multicycle_adder_top.sv
// Button/switch adder that processes one CHUNK_W digit per clock.
// Sum/CO/OVF are only written when the last digit completes.
module multicycle_adder_top
   import adder_pkg::*;
#(
   parameter int WIDTH   = 16,
   parameter int CHUNK_W = 4
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             LoadB,
   input  logic             Run,
   input  logic             Sub,
   input  logic [WIDTH-1:0] SW,
   output logic [WIDTH-1:0] Aval,
   output logic [WIDTH-1:0] Bval,
   output logic [WIDTH-1:0] Sum,
   output logic             CO,
   output logic             OVF,
   output logic             Busy,
   output logic             Done
);

   localparam int NCHUNK = nchunk_f(WIDTH, CHUNK_W);
   localparam int IDX_W  = idxw_f(NCHUNK);
   localparam logic [IDX_W-1:0] LAST = IDX_W'(NCHUNK - 1);
   localparam logic [WIDTH-1:0] CMASK = WIDTH'({CHUNK_W{1'b1}});

   state_t state_q, state_d;
   logic             run_q;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic [WIDTH-1:0] part_q, part_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             co_q, co_d;
   logic             ovf_q, ovf_d;
   logic             carry_q, carry_d;
   logic             sub_q, sub_d;

   logic             press;
   logic [31:0]      off;
   logic [CHUNK_W-1:0] ch_a, ch_b, ch_s;
   logic             ch_c;

   assign press = !Run && run_q;
   assign off   = 32'(idx_q) * 32'(CHUNK_W);
   assign ch_a  = CHUNK_W'(a_q >> off);
   assign ch_b  = CHUNK_W'(b_q >> off) ^ {CHUNK_W{sub_q}};

   chunk_adder #(
      .CHUNK_W (CHUNK_W)
   ) u_add (
      .a    (ch_a),
      .b    (ch_b),
      .cin  (carry_q),
      .s    (ch_s),
      .cout (ch_c)
   );

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      part_d  = part_q;
      idx_d   = idx_q;
      co_d    = co_q;
      ovf_d   = ovf_q;
      carry_d = carry_q;
      sub_d   = sub_q;
      unique case (state_q)
         IDLE: begin
            // The B load precedes the start, so a same-cycle
            // press computes with the freshly loaded B.
            if (!LoadB) b_d = SW;
            if (press) begin
               a_d     = SW;
               sub_d   = Sub;
               carry_d = Sub;
               idx_d   = '0;
               part_d  = '0;
               state_d = COMPUTE;
            end
         end
         COMPUTE: begin
            part_d  = (part_q & ~(CMASK << off))
                    | (WIDTH'(ch_s) << off);
            carry_d = ch_c;
            idx_d   = idx_q + IDX_W'(1);
            if (idx_q == LAST) begin
               sum_d   = part_d;
               co_d    = ch_c;
               ovf_d   = (a_q[WIDTH-1] == (b_q[WIDTH-1] ^ sub_q))
                      && (part_d[WIDTH-1] != a_q[WIDTH-1]);
               idx_d   = '0;
               state_d = DONE;
            end
         end
         DONE: begin
            if (Run) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q <= IDLE;
         run_q   <= 1'b1;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         part_q  <= '0;
         idx_q   <= '0;
         co_q    <= 1'b0;
         ovf_q   <= 1'b0;
         carry_q <= 1'b0;
         sub_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         run_q   <= Run;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         part_q  <= part_d;
         idx_q   <= idx_d;
         co_q    <= co_d;
         ovf_q   <= ovf_d;
         carry_q <= carry_d;
         sub_q   <= sub_d;
      end
   end

   assign Aval = a_q;
   assign Bval = b_q;
   assign Sum  = sum_q;
   assign CO   = co_q;
   assign OVF  = ovf_q;
   assign Busy = (state_q == COMPUTE);
   assign Done = (state_q == DONE);

endmodule

// File: tb/tb_multicycle_adder_top.sv
// Random and directed checks of the 16/4 adder plus a 16/16 twin
// driven by the same buttons, against an integer-arithmetic model.
module tb_multicycle_adder_top;

   localparam int W = 16;

   logic         Clk = 1'b0;
   logic         Reset, LoadB, Run, Sub;
   logic [W-1:0] SW;
   logic [W-1:0] Aval, Bval, Sum;
   logic         CO, OVF, Busy, Done;
   logic [W-1:0] Aval1, Bval1, Sum1;
   logic         CO1, OVF1, Busy1, Done1;

   int total = 0;
   int bad   = 0;

   always #5 Clk = ~Clk;

   multicycle_adder_top #(.WIDTH(W), .CHUNK_W(4)) dut (
      .Clk(Clk), .Reset(Reset), .LoadB(LoadB), .Run(Run),
      .Sub(Sub), .SW(SW), .Aval(Aval), .Bval(Bval), .Sum(Sum),
      .CO(CO), .OVF(OVF), .Busy(Busy), .Done(Done)
   );

   multicycle_adder_top #(.WIDTH(W), .CHUNK_W(16)) dut1 (
      .Clk(Clk), .Reset(Reset), .LoadB(LoadB), .Run(Run),
      .Sub(Sub), .SW(SW), .Aval(Aval1), .Bval(Bval1), .Sum(Sum1),
      .CO(CO1), .OVF(OVF1), .Busy(Busy1), .Done(Done1)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sub, output logic [W-1:0] s,
                        output logic co, output logic ovf);
      longint ua, ub, u;
      int sa, sb, r;
      ua = longint'(a);
      ub = longint'(b);
      sa = int'($signed(a));
      sb = int'($signed(b));
      if (sub) begin
         u  = ua - ub + 65536;
         co = (ua >= ub);
         r  = sa - sb;
      end else begin
         u  = ua + ub;
         co = (u > 65535);
         r  = sa + sb;
      end
      s   = W'(u % 65536);
      ovf = (r > 32767) || (r < -32768);
   endtask

   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sub, input bit hold);
      logic [W-1:0] es, prev;
      logic eco, eov;
      int n, nb;
      model(a, b, sub, es, eco, eov);
      SW = b; LoadB = 1'b0;
      step();
      LoadB = 1'b1;
      step();
      chk("bval_load", Bval, b);
      prev = Sum;
      SW = a; Sub = sub; Run = 1'b0;
      step();
      chk("busy_start", Busy, 1);
      n = 0;
      while (!Done && n < 10) begin
         chk("sum_hold", Sum, prev);
         LoadB = 1'($urandom);
         SW    = W'($urandom);
         Sub   = 1'($urandom);
         step();
         n++;
         if (n == 1) chk("w16_done", Done1, 1);
      end
      chk("latency", n, 4);
      chk("sum", Sum, es);
      chk("co", CO, eco);
      chk("ovf", OVF, eov);
      chk("aval", Aval, a);
      chk("bval_keep", Bval, b);
      chk("w16_sum", Sum1, es);
      chk("w16_co", CO1, eco);
      chk("w16_ovf", OVF1, eov);
      LoadB = 1'b1;
      if (hold) begin
         nb = 0;
         for (int i = 0; i < 20; i++) begin
            step();
            if (Busy) nb++;
         end
         chk("hold_retrig", nb, 0);
         chk("hold_done", Done, 1);
         chk("hold_sum", Sum, es);
      end
      Run = 1'b1;
      step();
      chk("done_clr", Done, 0);
      chk("w16_done_clr", Done1, 0);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_a"}, Aval, 0);
      chk({tag, "_b"}, Bval, 0);
      chk({tag, "_s"}, Sum, 0);
      chk({tag, "_f"}, {28'd0, CO, OVF, Busy, Done}, 0);
      chk({tag, "_w16"}, {Sum1, CO1, OVF1, Busy1, Done1}, 0);
   endtask

   initial begin
      Reset = 1'b0; Run = 1'b1; LoadB = 1'b1; Sub = 1'b0; SW = '0;
      step();
      step();
      chk_zero("rst");
      Reset = 1'b1;
      step();

      do_op(16'h0004, 16'h0008, 1'b0, 1'b0);
      do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
      do_op(16'h0005, 16'h0008, 1'b1, 1'b0);
      do_op(16'h0008, 16'h0005, 1'b1, 1'b0);
      do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
      do_op(16'h8000, 16'h0001, 1'b1, 1'b0);
      do_op(16'h0004, 16'h0008, 1'b0, 1'b0);
      do_op(16'h1234, 16'h0F0F, 1'b0, 1'b1);

      SW = 16'h0003; LoadB = 1'b0;
      step();
      LoadB = 1'b1; SW = 16'h0005; Run = 1'b0;
      step();
      step();
      chk("mid_busy", Busy, 1);
      Reset = 1'b0;
      #1;
      chk_zero("abort");
      Run = 1'b1;
      step();
      Reset = 1'b1;
      step();
      chk("abort_idle", {Busy, Done}, 0);

      for (int k = 0; k < 40; k++)
         do_op(W'($urandom), W'($urandom), 1'($urandom), 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/multicycle_adder_top.md
Name: multicycle_adder_top

Overview:
- Parametrised successor to the lab4 adder toplevel, keeping the same button/switch interface.
- Inputs: B is loaded from SW with LoadB; a Run press adds or subtracts SW (taken as A) and B.
- Computes one CHUNK_W-bit digit per clock through a single shared chunk adder, so area is traded for latency.
- Adds a subtract mode, signed-overflow flag, Busy/Done status and a registered result. Hex display decode stays external.

Parameters:
- WIDTH, 16, operand/result width; must be a multiple of CHUNK_W.
- CHUNK_W, 4, bits processed per cycle; 1 ≤ CHUNK_W ≤ WIDTH.
- NCHUNK, WIDTH/CHUNK_W, derived localparam, not overridable.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  asynchronous, active-low reset (0 = reset).
- LoadB  in  1  active-low button; while low and idle, B is loaded from SW.
- Run  in  1  active-low button; a press (high→low) starts an operation.
- Sub  in  1  mode select: 0 = add (SW+B), 1 = subtract (SW−B). Sampled at start.
- SW  in  WIDTH  switch input; source of B at load and of A at start.
- Aval  out  WIDTH  A operand register (for display).
- Bval  out  WIDTH  B operand register (for display).
- Sum  out  WIDTH  registered result.
- CO  out  1  carry-out of last op; for subtract, 1 = no borrow.
- OVF  out  1  two's-complement overflow of last op.
- Busy  out  1  high while in COMPUTE.
- Done  out  1  high in DONE state.

Behaviour:
- Reset (async, Reset=0): state=IDLE; Aval, Bval, Sum = 0; CO, OVF, Busy, Done = 0; internal chunk index = 0; carry = 0; run_q = 1.
- run_q is a one-cycle registered copy of Run. A press is `!Run && run_q`. Holding Run low never retriggers.
- IDLE:
  - LoadB=0 → Bval <= SW every cycle it is held.
  - Press → Aval <= SW; latch Sub; carry <= Sub; idx <= 0; partial result cleared; go to COMPUTE.
  - If press and LoadB=0 occur in the same cycle, the B load happens first: Bval <= SW, then the operation uses the new Bval.
- COMPUTE (Busy=1):
  - Each cycle: {c, s} = A[idx] + (B[idx] ^ {CHUNK_W{SubLatched}}) + carry, where [idx] is chunk idx of CHUNK_W bits.
  - Write s into partial chunk idx; carry <= c; idx <= idx+1.
  - LoadB, Run, Sub and SW are ignored.
  - On the cycle processing idx = NCHUNK−1: Sum <= final partial result; CO <= final carry; OVF <= (A[msb] == B'[msb]) && (Sum[msb] != A[msb]), where B' is the inverted B for subtract; go to DONE.
- Sum, CO and OVF hold their previous values throughout COMPUTE and change only at completion.
- Latency: the press-detect edge counts as edge 0; Sum/CO/OVF are updated and Done rises at edge NCHUNK. For 16/4 that is 4 edges after detection.
- DONE (Done=1): waits for Run=1 (button released), then goes to IDLE. A LoadB press in DONE is ignored.
- Reset asserted mid-operation aborts immediately to reset values. No partial result is ever exposed on Sum.
- CHUNK_W = WIDTH (NCHUNK=1) is legal: single-cycle compute.

Decomposition:
- Shared package adder_pkg:
  - state enum state_t {IDLE, COMPUTE, DONE}.
  - Helper function for NCHUNK.
- Sub-module chunk_adder (combinational, parameter CHUNK_W): a, b, cin → s, cout; instantiated once.
- The top contains the FSM, the operand/result registers and the chunk multiplexing.

Test Plan (WIDTH=16, CHUNK_W=4):
- LoadB=0 with SW=0x0008, release; Sub=0; SW=0x0004; press Run.
  - Busy=1 for 4 cycles, then Sum=0x000C, CO=0, OVF=0, Done=1.
  - Release Run → IDLE, Done=0.
- Carry chain: B=0x0001, A=0xFFFF add → Sum=0x0000, CO=1, OVF=0.
- Subtract: B=0x0008, A=0x0005, Sub=1 → Sum=0xFFFD, CO=0, OVF=0.
  - Then A=0x0008, B=0x0005 → Sum=0x0003, CO=1.
- Overflow: B=0x0001, A=0x7FFF add → Sum=0x8000, OVF=1.
  - Then A=0x8000, B=0x0001 subtract → Sum=0x7FFF, OVF=1.
- Robustness, starting from a prior result Sum=0x000C:
  - Toggle LoadB with SW=0x1234 during COMPUTE → Bval unchanged, result correct.
  - Hold Run low 20 cycles → exactly one operation.
  - Assert Reset at the 2nd COMPUTE cycle → all outputs 0, state IDLE.
  - Rerun with CHUNK_W=16 → Done after 1 edge.
